dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared data memory (`data_mem`). Port 0 is the pipeline's load/store path; port 1 is the debug/loader path. Each request passes through an alignment/range check, then a single memory access, then a held response. The block owns `data_mem`'s read enable, write enable, memory type, address and write data, so no other block may drive them.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_req_check.sv | 55 +++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the data-memory arbiter.
//               Holds the memory access type encoding, the sequencer
//               state encoding and the access-size helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Memory access type as seen by data_mem.
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HALF  = 3'b001,
        WORD  = 3'b010,
        BYTEU = 3'b011,
        HALFU = 3'b100
    } mem_type_e;

    // Sequencer states: accept, single memory access, held response.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // Number of bytes touched by an access of the given type.
    // Undefined encodings report 1; they are rejected by the checker anyway.
    function automatic logic [2:0] size_of(mem_type_e t);
        case (t)
            HALF, HALFU: size_of = 3'd2;
            WORD:        size_of = 3'd4;
            default:     size_of = 3'd1;
        endcase
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_req_check.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_check
// Description : Combinational legality check for one latched memory request.
//               Flags misalignment, accesses running past DEPTH, stores of
//               the unsigned load-only types and undefined type encodings.
// Ports       : type_i  [2:0]    access type
//               addr_i  [AW-1:0] byte address
//               write_i          1 = store
//               err_o            1 = request must not reach data_mem
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_req_check
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic [2:0]    type_i,
    input  logic [AW-1:0] addr_i,
    input  logic          write_i,
    output logic          err_o
);

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    mem_type_e   w_type;
    logic [AW:0] w_end;
    logic        w_align_err;
    logic        w_range_err;
    logic        w_type_err;

    always_comb begin
        w_type      = mem_type_e'(type_i);
        // One extra bit so an address near the top of the space cannot wrap.
        w_end       = {1'b0, addr_i} + (AW+1)'(size_of(w_type));
        w_range_err = (w_end > c_DEPTH);
        w_align_err = 1'b0;
        w_type_err  = 1'b0;
        case (w_type)
            BYTE: ;
            BYTEU: w_type_err = write_i;
            HALF:  w_align_err = addr_i[0];
            HALFU: begin
                w_align_err = addr_i[0];
                w_type_err  = write_i;
            end
            WORD:  w_align_err = |addr_i[1:0];
            default: w_type_err = 1'b1;
        endcase
        err_o = w_align_err | w_range_err | w_type_err;
    end

endmodule : dmem_req_check
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter and sequencer for data_mem.
//               Port 0 = pipeline load/store, port 1 = debug/loader.
//               One request in flight: IDLE (accept) -> ACCESS (single
//               memory cycle) -> RESP (response held until taken).
// Ports       : clock, reset          clock, synchronous active-high reset
//               req_valid/ready [1:0] request handshake per port
//               req_write/type/addr/wdata  request payload per port
//               rsp_valid/ready [1:0] response handshake per port
//               rsp_rdata [31:0]      load data (shared), rsp_err reject flag
//               mem_red_enable, mem_write_enable, mem_type, mem_addr,
//               mem_wdata             data_mem controls (owned here)
//               mem_redata [31:0]     combinational read data from data_mem
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [1:0][2:0]     req_type,
    input  logic [1:0][AW-1:0]  req_addr,
    input  logic [1:0][31:0]    req_wdata,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    output logic                mem_red_enable,
    output logic                mem_write_enable,
    output logic [2:0]          mem_type,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_redata
);

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           id_q, id_d;
    logic           write_q, write_d;
    logic [2:0]     type_q, type_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    logic           w_grant;
    logic           w_hs;
    logic           w_err;

    dmem_req_check #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_check (
        .type_i  (type_q),
        .addr_i  (addr_q),
        .write_i (write_q),
        .err_o   (w_err)
    );

    always_comb begin
        // Contention goes to the port that was not served last; otherwise
        // the single valid port wins (port 0 when nothing is valid, unused).
        w_grant = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        w_hs    = (state_q == IDLE) && (|req_valid);

        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        write_d      = write_q;
        type_d       = type_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;

        req_ready        = 2'b00;
        rsp_valid        = 2'b00;
        rsp_err          = 1'b0;
        mem_red_enable   = 1'b0;
        mem_write_enable = 1'b0;
        mem_type         = 3'b000;
        mem_addr         = 32'd0;
        mem_wdata        = 32'd0;

        case (state_q)
            IDLE: begin
                if (w_hs) begin
                    req_ready[w_grant] = 1'b1;
                    state_d            = ACCESS;
                    last_grant_d       = w_grant;
                    id_d               = w_grant;
                    write_d            = req_write[w_grant];
                    type_d             = req_type[w_grant];
                    addr_d             = req_addr[w_grant];
                    wdata_d            = req_wdata[w_grant];
                end
            end
            ACCESS: begin
                state_d = RESP;
                err_d   = w_err;
                // Rejected requests and stores both return zero data.
                rdata_d = (!w_err && !write_q) ? mem_redata : 32'd0;
                if (!w_err) begin
                    mem_red_enable   = ~write_q;
                    mem_write_enable = write_q;
                    mem_type         = type_q;
                    mem_addr         = 32'(addr_q);
                    mem_wdata        = wdata_q;
                end
            end
            RESP: begin
                rsp_valid[id_q] = 1'b1;
                rsp_err         = err_q;
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_rdata = rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            write_q      <= 1'b0;
            type_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            write_q      <= write_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a byte-array model
//               of data_mem and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_write;
    logic [1:0][2:0]    req_type;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][31:0]   req_wdata;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               mem_red_enable;
    logic               mem_write_enable;
    logic [2:0]         mem_type;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_redata;

    always #5 clock = ~clock;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_type         (req_type),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_red_enable   (mem_red_enable),
        .mem_write_enable (mem_write_enable),
        .mem_type         (mem_type),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_redata       (mem_redata)
    );

    // ---------------- data_mem model (little-endian bytes) ----------------
    logic [7:0] tb_mem [0:DEPTH-1];
    logic       mem_clear;
    logic [4:0] ra0, ra1, ra2, ra3;
    int         strobe_cnt;
    int         both_ready_cnt;

    assign ra0 = mem_addr[4:0];
    assign ra1 = ra0 + 5'd1;
    assign ra2 = ra0 + 5'd2;
    assign ra3 = ra0 + 5'd3;

    always_ff @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'h00;
        end else if (mem_write_enable) begin
            tb_mem[ra0] <= mem_wdata[7:0];
            if (mem_type == 3'b001 || mem_type == 3'b010) tb_mem[ra1] <= mem_wdata[15:8];
            if (mem_type == 3'b010) begin
                tb_mem[ra2] <= mem_wdata[23:16];
                tb_mem[ra3] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        mem_redata = 32'd0;
        case (mem_type)
            3'b000:  mem_redata = {{24{tb_mem[ra0][7]}}, tb_mem[ra0]};
            3'b011:  mem_redata = {24'd0, tb_mem[ra0]};
            3'b001:  mem_redata = {{16{tb_mem[ra1][7]}}, tb_mem[ra1], tb_mem[ra0]};
            3'b100:  mem_redata = {16'd0, tb_mem[ra1], tb_mem[ra0]};
            3'b010:  mem_redata = {tb_mem[ra3], tb_mem[ra2], tb_mem[ra1], tb_mem[ra0]};
            default: mem_redata = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_clear) strobe_cnt <= 0;
        else if (mem_red_enable || mem_write_enable) strobe_cnt <= strobe_cnt + 1;
    end

    always_ff @(negedge clock) begin
        if (mem_clear) both_ready_cnt <= 0;
        else if (req_ready == 2'b11) both_ready_cnt <= both_ready_cnt + 1;
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        logic        port;
        logic        write;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic p, logic w, logic [2:0] t, logic [31:0] a,
                                logic [31:0] d, logic e, logic [31:0] r);
        vec_t v;
        v.port = p; v.write = w; v.typ = t; v.addr = a;
        v.wdata = d; v.exp_err = e; v.exp_rdata = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive a request on port p and wait (bounded) for its handshake.
    // Returns positioned one step after the handshake edge (ACCESS cycle).
    task automatic issue(input logic p, input logic w, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_rd, input logic push);
        logic got;
        sb_t  e;
        req_write[p] = w;
        req_type[p]  = t;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_valid[p] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (req_ready[p]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("req_accept", got, 1'b1);
        step();
        req_valid[p] = 1'b0;
        if (push) begin
            e.port = p; e.err = e_err; e.rdata = e_rd;
            sbq.push_back(e);
        end
    endtask

    task automatic pop_check();
        sb_t e;
        chk("sb_nonempty", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rsp_valid", rsp_valid, e.port ? 2'b10 : 2'b01);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_rdata", rsp_rdata, e.rdata);
        end
    endtask

    // Called in the ACCESS cycle; waits for the response, checks, takes it.
    task automatic wait_rsp(input logic p, input logic check_lat);
        int lat;
        lat = 1;
        while (!rsp_valid[p] && lat < 12) begin
            step();
            lat++;
        end
        if (check_lat) chk("rsp_latency", lat, 2);
        pop_check();
        rsp_ready[p] = 1'b1;
        step();
        rsp_ready[p] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] snap [0:DEPTH-1];
        int         s0;
        logic       same;
        snap = tb_mem;
        s0   = strobe_cnt;
        issue(v.port, v.write, v.typ, v.addr, v.wdata, v.exp_err, v.exp_rdata, 1'b1);
        wait_rsp(v.port, 1'b1);
        chk("strobe_count", strobe_cnt - s0, v.exp_err ? 0 : 1);
        if (v.exp_err) begin
            same = 1'b1;
            for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== snap[i]) same = 1'b0;
            chk("mem_unchanged", same, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        int         n;

        // port, write, type, addr, wdata, exp_err, exp_rdata
        vecs.push_back(mk(0, 1, WORD,   32'd4,  32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(0, 0, WORD,   32'd4,  32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 1, BYTE,   32'd4,  32'h00000080, 0, 32'h0));
        vecs.push_back(mk(0, 0, BYTE,   32'd4,  32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mk(1, 0, BYTEU,  32'd4,  32'h0,        0, 32'h00000080));
        vecs.push_back(mk(0, 0, HALF,   32'd6,  32'h0,        0, 32'hFFFFDEAD));
        vecs.push_back(mk(1, 0, HALFU,  32'd6,  32'h0,        0, 32'h0000DEAD));
        vecs.push_back(mk(0, 0, HALF,   32'd3,  32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 1, WORD,   32'd30, 32'h11111111, 1, 32'h0));
        vecs.push_back(mk(1, 1, HALFU,  32'd8,  32'h22222222, 1, 32'h0));
        vecs.push_back(mk(0, 0, 3'b101, 32'd0,  32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 1, BYTEU,  32'd0,  32'h000000FF, 1, 32'h0));
        vecs.push_back(mk(0, 1, WORD,   32'd28, 32'h12345678, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD,   32'd28, 32'h0,        0, 32'h12345678));
        vecs.push_back(mk(0, 0, BYTEU,  32'd31, 32'h0,        0, 32'h00000012));
        vecs.push_back(mk(1, 0, BYTEU,  32'd32, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 0, WORD,   32'd32, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 1, HALF,   32'd30, 32'hAAAA5555, 0, 32'h0));
        vecs.push_back(mk(1, 0, WORD,   32'd28, 32'h0,        0, 32'h55555678));
        vecs.push_back(mk(0, 0, WORD,   32'd4,  32'h0,        0, 32'hDEADBE80));

        mem_clear = 1'b1;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_type  = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        mem_clear = 1'b0;
        reset     = 1'b0;
        #1;

        // Reset state
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err",   rsp_err, 1'b0);
        chk("reset_strobes",   {mem_red_enable, mem_write_enable}, 2'b00);
        chk("reset_mem_addr",  mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_mem_type",  mem_type, 3'b000);
        step();

        // Both ports valid from reset: strict alternation 0,1,0.
        req_type  = {3'b011, 3'b011};
        req_addr  = '0;
        req_write = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (req_ready == 2'b00 && n < 10) begin
                step();
                n++;
            end
            chk("arb_grant", req_ready, exp_g);
            sbq.push_back('{port: exp_g[1], err: 1'b0, rdata: 32'h0});
            step();
            step();
            pop_check();
        end
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b00;
        step();

        // Table-driven single requests.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Response backpressure with port 1 waiting.
        issue(1'b0, 1'b0, WORD, 32'd4, 32'h0, 1'b0, 32'hDEADBE80, 1'b1);
        req_write[1] = 1'b0;
        req_type[1]  = BYTEU;
        req_addr[1]  = 32'd4;
        req_valid[1] = 1'b1;
        step();
        chk("bp_rsp_valid_first", rsp_valid, 2'b01);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBE80);
            chk("bp_req_ready", req_ready, 2'b00);
            step();
        end
        wait_rsp(1'b0, 1'b0);
        #1;
        chk("bp_port1_ready_after", req_ready, 2'b10);
        issue(1'b1, 1'b0, BYTEU, 32'd4, 32'h0, 1'b0, 32'h00000080, 1'b1);
        wait_rsp(1'b1, 1'b1);

        // Reset during the ACCESS cycle of a store.
        issue(1'b0, 1'b1, WORD, 32'd8, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
        chk("rst_access_we", mem_write_enable, 1'b1);
        chk("rst_access_addr", mem_addr, 32'd8);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err",   rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_strobes",   {mem_red_enable, mem_write_enable}, 2'b00);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_store_committed", {tb_mem[11], tb_mem[10], tb_mem[9], tb_mem[8]}, 32'hCAFEF00D);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rst_no_response", rsp_valid, 2'b00);
        end
        run_vec(mk(1'b0, 1'b0, WORD, 32'd8, 32'h0, 1'b0, 32'hCAFEF00D));

        chk("sb_empty_at_end", sbq.size(), 0);
        chk("never_both_ready", both_ready_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
